computer_4bit_loader: RTL and testbench

Controller that sequences the 4-bit computer through its two phases: it streams a program/data image into the computer's instruction and data memories while holding the computer in load mode, then releases it to run for a fixed cycle budget and captures the output nibble and flags. It sits between an image source (ROM, host interface or testbench model) and the `computer_4bit` load/run ports, replacing hand-sequenced load loops.

---
 rtl/computer_4bit_loader_pkg.sv | 20 ++
 rtl/computer_4bit_loader_if.sv | 32 +++
 rtl/computer_4bit_loader_run_timer.sv | 32 +++
 rtl/computer_4bit_loader.sv | 155 +++++++++++++++
 tb/tb_computer_4bit_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/computer_4bit_loader_pkg.sv
// Shared definitions for the 4-bit computer and the tools around it.
// Contents: loader FSM state encoding, bus widths and the HLT opcode used
// by image builders and benches.
package computer_4bit_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned INS_W  = 8;
    localparam int unsigned DATA_W = 4;

    localparam logic [INS_W-1:0] HLT_OP = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/computer_4bit_loader_if.sv
// Image-source bus between the loader (master) and an image provider (slave).
//   img_req   : master requests the word at img_addr
//   img_addr  : image word index
//   img_valid : slave presents img_ins/img_data for img_addr
//   img_ins   : instruction byte
//   img_data  : data nibble
interface computer_4bit_loader_if;
    import computer_4bit_pkg::*;

    logic              img_req;
    logic [ADDR_W-1:0] img_addr;
    logic              img_valid;
    logic [INS_W-1:0]  img_ins;
    logic [DATA_W-1:0] img_data;

    modport master (
        output img_req,
        output img_addr,
        input  img_valid,
        input  img_ins,
        input  img_data
    );

    modport slave (
        input  img_req,
        input  img_addr,
        output img_valid,
        output img_ins,
        output img_data
    );

endinterface

// File: rtl/computer_4bit_loader_run_timer.sv
// run_timer: loadable down-counter with a zero flag.
//   clk, rst   : clock, asynchronous active-low reset
//   load_i     : load load_val_i (has priority over counting)
//   load_val_i : value to load
//   en_i       : count down by one while non-zero
//   zero_o     : counter is zero
module run_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/computer_4bit_loader.sv
// computer_4bit_loader: streams an image into the 4-bit computer while it is
// held in load mode, then releases it for RUN_CYCLES clocks and captures the
// output nibble and flags.
//   clk, rst                          : clock, asynchronous active-low reset
//   start, abort, n_words             : job control
//   img (master)                      : image-source request bus
//   cpu_rst, cpu_ins_address, cpu_ins, cpu_d_in : computer load/run ports
//   cpu_d_out, cpu_zf, cpu_cf         : computer outputs
//   busy, done, err                   : job status (err is a 1-cycle pulse)
//   result, result_zf, result_cf      : captured computer outputs
module computer_4bit_loader
    import computer_4bit_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RUN_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [4:0]            n_words,
    computer_4bit_loader_if.master img,
    output logic                  cpu_rst,
    output logic [ADDR_W-1:0]     cpu_ins_address,
    output logic [INS_W-1:0]      cpu_ins,
    output logic [DATA_W-1:0]     cpu_d_in,
    input  logic [DATA_W-1:0]     cpu_d_out,
    input  logic                  cpu_zf,
    input  logic                  cpu_cf,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     result,
    output logic                  result_zf,
    output logic                  result_cf
);

    localparam int unsigned TW = $clog2(RUN_CYCLES + 1);

    state_t            state_q;
    logic [4:0]        n_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              img_req_q;
    logic              cpu_rst_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [INS_W-1:0]  cpu_ins_q;
    logic [DATA_W-1:0] cpu_din_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] result_q;
    logic              result_zf_q;
    logic              result_cf_q;

    logic tmr_zero;

    // Timer is loaded on the HOLD->RUN edge so it reads RUN_CYCLES-1 in the
    // first RUN cycle; capture happens on the edge where it reads zero.
    run_timer #(.W(TW)) u_run_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_HOLD),
        .load_val_i (TW'(RUN_CYCLES - 1)),
        .en_i       (state_q == ST_RUN),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            img_req_q   <= 1'b0;
            cpu_rst_q   <= 1'b1;
            cpu_addr_q  <= '0;
            cpu_ins_q   <= '0;
            cpu_din_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            result_zf_q <= 1'b0;
            result_cf_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (abort) begin
                state_q   <= ST_IDLE;
                img_req_q <= 1'b0;
                cpu_rst_q <= 1'b1;
                busy_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if ((n_words == 5'd0) || (32'(n_words) > DEPTH)) begin
                                err_q <= 1'b1;
                            end else begin
                                n_q       <= n_words;
                                cnt_q     <= '0;
                                img_req_q <= 1'b1;
                                busy_q    <= 1'b1;
                                done_q    <= 1'b0;
                                state_q   <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (img_req_q && img.img_valid) begin
                            cpu_addr_q <= cnt_q;
                            cpu_ins_q  <= img.img_ins;
                            cpu_din_q  <= img.img_data;
                            if ({1'b0, cnt_q} == (n_q - 5'd1)) begin
                                img_req_q <= 1'b0;
                                state_q   <= ST_HOLD;
                            end else begin
                                cnt_q <= cnt_q + ADDR_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        cpu_rst_q <= 1'b0;
                        state_q   <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (tmr_zero) begin
                            result_q    <= cpu_d_out;
                            result_zf_q <= cpu_zf;
                            result_cf_q <= cpu_cf;
                            cpu_rst_q   <= 1'b1;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign img.img_req     = img_req_q;
    assign img.img_addr    = cnt_q;
    assign cpu_rst         = cpu_rst_q;
    assign cpu_ins_address = cpu_addr_q;
    assign cpu_ins         = cpu_ins_q;
    assign cpu_d_in        = cpu_din_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign result          = result_q;
    assign result_zf       = result_zf_q;
    assign result_cf       = result_cf_q;

endmodule

// File: tb/tb_computer_4bit_loader.sv
// Directed bench for computer_4bit_loader. The computer is replaced by a stub
// whose outputs carry the expected answer only in the 32nd RUN cycle, so a
// capture on any other edge shows up as a wrong result.
module tb_computer_4bit_loader;
    import computer_4bit_pkg::*;

    localparam int unsigned RUNC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  n_words;
    logic        cpu_rst;
    logic [3:0]  cpu_ins_address;
    logic [7:0]  cpu_ins;
    logic [3:0]  cpu_d_in;
    logic [3:0]  cpu_d_out;
    logic        cpu_zf;
    logic        cpu_cf;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  result;
    logic        result_zf;
    logic        result_cf;

    computer_4bit_loader_if img_bus();

    computer_4bit_loader #(.DEPTH(16), .RUN_CYCLES(RUNC)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .n_words         (n_words),
        .img             (img_bus),
        .cpu_rst         (cpu_rst),
        .cpu_ins_address (cpu_ins_address),
        .cpu_ins         (cpu_ins),
        .cpu_d_in        (cpu_d_in),
        .cpu_d_out       (cpu_d_out),
        .cpu_zf          (cpu_zf),
        .cpu_cf          (cpu_cf),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .result          (result),
        .result_zf       (result_zf),
        .result_cf       (result_cf)
    );

    logic [7:0]  rom_ins  [16];
    logic [3:0]  rom_data [16];
    logic        stall_mode = 1'b0;
    logic [3:0]  cap_val = 4'd0;
    logic        cap_zf = 1'b0;
    logic        cap_cf = 1'b0;
    logic [7:0]  req_cnt = '0;
    logic [7:0]  run_cnt = '0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] i;
        logic [3:0] d;
    } wr_t;

    wr_t log_q[$];
    wr_t prev_wr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        req_cnt <= img_bus.img_req ? req_cnt + 8'd1 : 8'd0;
        run_cnt <= cpu_rst ? 8'd0 : run_cnt + 8'd1;
    end

    // Image source: in stall mode valid is low on the first request cycle and
    // every other cycle after it. Computer stub answers only in RUN cycle 32.
    always_comb begin
        img_bus.img_valid = stall_mode ? req_cnt[0] : 1'b1;
        img_bus.img_ins   = rom_ins[img_bus.img_addr];
        img_bus.img_data  = rom_data[img_bus.img_addr];
        cpu_d_out = (run_cnt == 8'(RUNC - 1)) ? cap_val : 4'hE;
        cpu_zf    = (run_cnt == 8'(RUNC - 1)) ? cap_zf  : 1'b1;
        cpu_cf    = (run_cnt == 8'(RUNC - 1)) ? cap_cf  : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [4:0] n, input int unsigned exp_lat,
                           input logic [3:0] prev_res);
        int unsigned c0;
        wr_t cur;
        bit seen;
        log_q.delete();
        @(negedge clk);
        n_words = n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        check({tag, "_done_clr"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_res_hold"}, 32'(result), 32'(prev_res));
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            cur = '{cpu_ins_address, cpu_ins, cpu_d_in};
            if (cur !== prev_wr) begin
                log_q.push_back(cur);
                prev_wr = cur;
            end
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, cyc - c0, exp_lat);
        check({tag, "_nwrites"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < int'(n); i++) begin
            if (i < log_q.size())
                check($sformatf("%s_wr%0d", tag, i), 32'(log_q[i]),
                      32'({i[3:0], rom_ins[i], rom_data[i]}));
        end
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(cap_val));
        check({tag, "_zf"}, 32'(result_zf), 32'(cap_zf));
        check({tag, "_cf"}, 32'(result_cf), 32'(cap_cf));
    endtask

    task automatic start_bad(input string tag, input logic [4:0] n);
        @(negedge clk);
        n_words = n;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_req"}, 32'(img_bus.img_req), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_err_pulse"}, 32'(err), 32'd0);
        check({tag, "_req2"}, 32'(img_bus.img_req), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_req"}, 32'(img_bus.img_req), 32'd0);
        check({tag, "_addr"}, 32'(img_bus.img_addr), 32'd0);
        check({tag, "_cpu_wr"}, 32'({cpu_ins_address, cpu_ins, cpu_d_in}), 32'd0);
        check({tag, "_status"}, 32'({busy, done, err}), 32'd0);
        check({tag, "_result"}, 32'({result, result_zf, result_cf}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        n_words = 5'd0;
        for (int i = 0; i < 16; i++) begin
            rom_ins[i]  = 8'h00;
            rom_data[i] = 4'h0;
        end
        rom_ins[0] = 8'h16; rom_ins[1] = 8'h02; rom_ins[2] = 8'h77;
        rom_ins[3] = 8'h01; rom_ins[4] = 8'h04; rom_ins[5] = HLT_OP;
        rom_data[1] = 4'h9;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;

        start_bad("nw0", 5'd0);
        start_bad("nw17", 5'd17);

        // Job 1: 6 words, no stalls. Latency start->done = N + 1 + RUN_CYCLES.
        cap_val = 4'd2; cap_zf = 1'b0; cap_cf = 1'b0;
        run_job("job1", 5'd6, 39, 4'd0);

        // Same job with stalls: 6 extra cycles, same write sequence.
        stall_mode = 1'b1;
        run_job("job1s", 5'd6, 45, 4'd2);
        stall_mode = 1'b0;

        // Back-to-back from DONE with the ADD image; result holds until capture.
        rom_ins[3] = 8'h00;
        cap_val = 4'hB;
        run_job("job2", 5'd6, 39, 4'd2);

        // Abort in RUN cycle 10.
        @(negedge clk);
        n_words = 5'd6;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100 && cpu_rst; k++) @(negedge clk);
        check("abort_in_run", 32'(cpu_rst), 32'd0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        check("abort_status", 32'({busy, done}), 32'd0);
        check("abort_req", 32'(img_bus.img_req), 32'd0);
        check("abort_result", 32'(result), 32'hB);
        repeat (40) @(negedge clk);
        check("abort_idle_done", 32'(done), 32'd0);
        check("abort_idle_result", 32'(result), 32'hB);

        // Reset during LOAD word 3.
        rom_ins[3] = 8'h01;
        cap_val = 4'd2;
        @(negedge clk);
        n_words = 5'd6;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && img_bus.img_addr != 4'd3; k++) @(negedge clk);
        check("rstmid_reach_w3", 32'(img_bus.img_addr), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("rstmid");
        @(negedge clk);
        rst = 1'b1;
        prev_wr = '0;
        run_job("restart", 5'd6, 39, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
